elevator_request_sched: RTL and testbench
=========================================

Name: elevator_request_sched

Overview:
- Upstream stage of the elevator state machine. Collects hall calls and cab button presses into a pending-floor bitmap.
- Picks the next target floor using a SCAN (continue-in-direction) policy.
- Issues that target to the state machine over a valid/ready handshake.
- Holds a door-dwell interval after each arrival before issuing the next target.

Parameters:
- FLOORS, 4, number of floors served; request bitmap width.
- FLOOR_W, 2, width of floor index; must satisfy 2**FLOOR_W >= FLOORS.
- DOOR_CYCLES, 8, clk cycles spent in DOOR after an arrival, range 1..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- hall_call  input  FLOORS  one bit per floor; each high cycle is a call request at that floor.
- cab_valid  input  1  cab button press strobe.
- cab_floor  input  FLOOR_W  floor selected by the cab press; sampled when cab_valid=1.
- cur_floor  input  FLOOR_W  current floor reported by the state machine.
- arrived  input  1  one-cycle pulse from the state machine: cab has stopped at cur_floor.
- target_valid  output  1  target_floor is valid.
- target_floor  output  FLOOR_W  next floor to travel to.
- target_ready  input  1  state machine accepts the target; transfer occurs on target_valid & target_ready.
- pending  output  FLOORS  registered request bitmap.
- dir_up  output  1  current scan direction: 1=up, 0=down.
- door_open  output  1  high during door dwell.

Behaviour:
- Reset values: pending=0, target_valid=0, target_floor=0, dir_up=1, door_open=0, FSM=IDLE, dwell counter=0.
- Request capture:
  - pending_next = pending | hall_call | (cab_valid ? onehot(cab_floor) : 0), then clear.
  - Clear rule: bit cur_floor is cleared on the arrived cycle.
  - Clear rule: bit cur_floor is cleared on every DOOR cycle (press at the open-door floor is absorbed).
  - Clear wins over a set of the same bit in the same cycle.
  - cab_floor >= FLOORS is ignored.
- Visibility: pending is registered; a press is visible on pending one cycle later.
- FSM states: IDLE, SELECT, ISSUE, MOVING, DOOR.
- IDLE:
  - If pending has a bit other than cur_floor set -> SELECT.
  - A press for cur_floor in IDLE -> DOOR directly (bit cleared, door_open=1 next cycle).
- SELECT (one cycle): compute the target.
  - If dir_up and any pending bit > cur_floor: target = lowest such floor.
  - Else if any pending bit < cur_floor: target = highest such floor, dir_up<=0.
  - Else if any pending bit > cur_floor: target = lowest such floor, dir_up<=1.
  - Else -> IDLE.
  - Then -> ISSUE.
- ISSUE:
  - target_valid=1; target_floor is stable until accepted.
  - On target_ready -> MOVING, target_valid<=0.
  - No retargeting while valid, even if a nearer request arrives.
- MOVING:
  - Wait for arrived; new presses still accumulate.
  - On arrived -> DOOR, dwell counter<=DOOR_CYCLES-1, door_open<=1.
  - arrived with cur_floor != target_floor (intermediate stop) is still served and cleared.
- DOOR:
  - Counter decrements each cycle; at 0 -> door_open<=0, go to SELECT if pending!=0, else IDLE.
  - door_open is high for exactly DOOR_CYCLES cycles.
- arrived outside MOVING is ignored for FSM purposes but still clears the pending bit.
- Latency: from a press in IDLE (cur_floor elsewhere), target_valid rises 3 cycles later (pending reg, IDLE->SELECT, SELECT->ISSUE).
- Reset mid-operation: all state returns to reset values on the next edge; in-flight target is dropped and pending is cleared.
- Dwell timing is in clk cycles only; no prescaler.

Test Plan:
- Reset, cur_floor=0, cab_valid=1 cab_floor=1 for one cycle -> pending=0010; target_valid=1 target_floor=1 three cycles later; held until target_ready.
- cur_floor=1, dir_up=1, pending set for floors 0 and 3 -> target_floor=3, dir_up stays 1. After arrived at 3 and dwell -> target_floor=0, dir_up=0.
- cur_floor=2, hall_call=0100 in IDLE -> no target; door_open=1 for exactly 8 cycles; pending returns to 0.
- In MOVING to floor 3, cab press floor 2, then arrived with cur_floor=2 -> bit 2 cleared, DOOR entered; then target_floor=3 reissued.
- target_ready held low for 20 cycles during ISSUE while pressing floor 0 -> target_floor unchanged, target_valid stays high; pending shows the new bit.
- Assert reset in MOVING with pending=1010 -> next cycle pending=0, target_valid=0, door_open=0, dir_up=1.

Source files
------------

// File: rtl/elevator_request_sched.sv
// elevator_request_sched
// Upstream request scheduler for the elevator state machine. Hall calls and
// cab presses accumulate in a pending-floor bitmap; a SCAN policy picks the
// next target, which is offered over a valid/ready handshake. After every
// arrival the doors dwell for a fixed number of cycles before the next
// target is chosen.

module elevator_request_sched #(
  parameter int FLOORS      = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  hall_call,
  input  logic               cab_valid,
  input  logic [FLOOR_W-1:0] cab_floor,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               arrived,
  output logic               target_valid,
  output logic [FLOOR_W-1:0] target_floor,
  input  logic               target_ready,
  output logic [FLOORS-1:0]  pending,
  output logic               dir_up,
  output logic               door_open
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_MOVING,
    S_DOOR
  } state_t;

  // Counter reload; the door stays open while the counter walks down to zero.
  localparam logic [7:0] DWELL_LOAD = 8'(DOOR_CYCLES - 1);

  // One-hot decode of a floor index. Indices at or above FLOORS decode to
  // zero, which is how out-of-range cab presses are dropped.
  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] idx);
    logic [FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (idx == FLOOR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  state_t             state_q;
  logic [FLOORS-1:0]  pending_q;
  logic [FLOORS-1:0]  pending_d;
  logic               targetValid_q;
  logic [FLOOR_W-1:0] targetFloor_q;
  logic               dirUp_q;
  logic               doorOpen_q;
  logic [7:0]         dwellCnt_q;

  logic [FLOORS-1:0]  cabMask;
  logic [FLOORS-1:0]  curMask;
  logic [FLOORS-1:0]  pressMask;
  logic [FLOORS-1:0]  clearMask;
  logic               idleHit;
  logic               otherPending;
  logic               clearCur;

  logic               haveAbove;
  logic               haveBelow;
  logic [FLOOR_W-1:0] lowAbove;
  logic [FLOOR_W-1:0] highBelow;

  // Merge new presses into the bitmap and clear the current floor whenever the cab is being served there.
  always_comb begin
    cabMask      = cab_valid ? onehot(cab_floor) : '0;
    curMask      = onehot(cur_floor);
    pressMask    = hall_call | cabMask;
    idleHit      = |((pressMask | pending_q) & curMask);
    otherPending = |(pending_q & ~curMask);
    clearCur     = arrived || (state_q == S_DOOR) || ((state_q == S_IDLE) && idleHit);
    clearMask    = clearCur ? curMask : '0;
    pending_d    = (pending_q | pressMask) & ~clearMask;
  end

  // Find the nearest pending floor above and below the cab for the SCAN choice.
  always_comb begin
    haveAbove = 1'b0;
    haveBelow = 1'b0;
    lowAbove  = '0;
    highBelow = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (FLOOR_W'(i) > cur_floor)) begin
        haveAbove = 1'b1;
        lowAbove  = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) < cur_floor)) begin
        haveBelow = 1'b1;
        highBelow = FLOOR_W'(i);
      end
    end
  end

  // Pending request register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Scheduler FSM with registered handshake, direction and door outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      targetValid_q <= 1'b0;
      targetFloor_q <= '0;
      dirUp_q       <= 1'b1;
      doorOpen_q    <= 1'b0;
      dwellCnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (idleHit) begin
            state_q    <= S_DOOR;
            doorOpen_q <= 1'b1;
            dwellCnt_q <= DWELL_LOAD;
          end else if (otherPending) begin
            state_q <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (dirUp_q && haveAbove) begin
            targetFloor_q <= lowAbove;
            targetValid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end else if (haveBelow) begin
            targetFloor_q <= highBelow;
            dirUp_q       <= 1'b0;
            targetValid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end else if (haveAbove) begin
            targetFloor_q <= lowAbove;
            dirUp_q       <= 1'b1;
            targetValid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_ISSUE: begin
          if (target_ready) begin
            targetValid_q <= 1'b0;
            state_q       <= S_MOVING;
          end
        end

        S_MOVING: begin
          if (arrived) begin
            state_q    <= S_DOOR;
            doorOpen_q <= 1'b1;
            dwellCnt_q <= DWELL_LOAD;
          end
        end

        S_DOOR: begin
          if (dwellCnt_q == 8'd0) begin
            doorOpen_q <= 1'b0;
            state_q    <= (|pending_q) ? S_SELECT : S_IDLE;
          end else begin
            dwellCnt_q <= dwellCnt_q - 8'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign target_valid = targetValid_q;
  assign target_floor = targetFloor_q;
  assign pending      = pending_q;
  assign dir_up       = dirUp_q;
  assign door_open    = doorOpen_q;

endmodule

// File: tb/tb_elevator_request_sched.sv
// tb_elevator_request_sched
// Table-driven vectors, hand-written corner sequences and a randomized run,
// all checked against a behavioural scheduler model that steps once per clock.

module tb_elevator_request_sched;

  localparam int FLOORS      = 4;
  localparam int FLOOR_W     = 2;
  localparam int DOOR_CYCLES = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [FLOORS-1:0]  hall_call;
  logic               cab_valid;
  logic [FLOOR_W-1:0] cab_floor;
  logic [FLOOR_W-1:0] cur_floor;
  logic               arrived;
  logic               target_valid;
  logic [FLOOR_W-1:0] target_floor;
  logic               target_ready;
  logic [FLOORS-1:0]  pending;
  logic               dir_up;
  logic               door_open;

  int total = 0;
  int bad   = 0;

  elevator_request_sched #(
    .FLOORS(FLOORS),
    .FLOOR_W(FLOOR_W),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hall_call(hall_call),
    .cab_valid(cab_valid),
    .cab_floor(cab_floor),
    .cur_floor(cur_floor),
    .arrived(arrived),
    .target_valid(target_valid),
    .target_floor(target_floor),
    .target_ready(target_ready),
    .pending(pending),
    .dir_up(dir_up),
    .door_open(door_open)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural model: a set of requested floors, what the scheduler is doing,
  // and how many more cycles the doors stay open.
  typedef enum {M_IDLE, M_SELECT, M_ISSUE, M_MOVING, M_DOOR} mphase_t;
  mphase_t mPhase    = M_IDLE;
  bit      mReq[FLOORS];
  int      mTarget   = 0;
  bit      mValid    = 1'b0;
  bit      mUp       = 1'b1;
  bit      mDoor     = 1'b0;
  int      mDoorLeft = 0;

  typedef struct {
    logic              rst;
    logic [FLOORS-1:0] hall;
    logic              cabV;
    logic [1:0]        cabF;
    logic [1:0]        cur;
    logic              arr;
    logic              rdy;
    logic              expValid;
    logic [1:0]        expTarget;
    logic [FLOORS-1:0] expPend;
    logic              expDir;
    logic              expDoor;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic rst, logic [3:0] hall, logic cabV, logic [1:0] cabF,
                                 logic [1:0] cur, logic arr, logic rdy, logic eV,
                                 logic [1:0] eT, logic [3:0] eP, logic eD, logic eO);
    vec_t v;
    v.rst = rst; v.hall = hall; v.cabV = cabV; v.cabF = cabF; v.cur = cur;
    v.arr = arr; v.rdy = rdy; v.expValid = eV; v.expTarget = eT; v.expPend = eP;
    v.expDir = eD; v.expDoor = eO;
    return v;
  endfunction

  function automatic logic [FLOORS-1:0] modelPend();
    logic [FLOORS-1:0] p;
    for (int f = 0; f < FLOORS; f++) p[f] = mReq[f];
    return p;
  endfunction

  task automatic checkOne(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit press[FLOORS];
    bit nextReq[FLOORS];
    int cur;
    bit hit, others, anyReq, clr;
    int lowUp, highDown;
    if (reset) begin
      mPhase = M_IDLE; mTarget = 0; mValid = 0; mUp = 1; mDoor = 0; mDoorLeft = 0;
      for (int f = 0; f < FLOORS; f++) mReq[f] = 0;
      return;
    end
    cur = int'(cur_floor);
    for (int f = 0; f < FLOORS; f++)
      press[f] = hall_call[f] || (cab_valid && (int'(cab_floor) == f));
    hit = press[cur] || mReq[cur];
    others = 0; anyReq = 0; lowUp = -1; highDown = -1;
    for (int f = 0; f < FLOORS; f++) begin
      if (mReq[f]) begin
        anyReq = 1;
        if (f != cur) others = 1;
        if (f > cur && lowUp < 0) lowUp = f;
        if (f < cur) highDown = f;
      end
    end
    clr = arrived || (mPhase == M_DOOR) || ((mPhase == M_IDLE) && hit);
    for (int f = 0; f < FLOORS; f++)
      nextReq[f] = (mReq[f] || press[f]) && !(clr && f == cur);
    case (mPhase)
      M_IDLE: begin
        if (hit) begin mPhase = M_DOOR; mDoor = 1; mDoorLeft = DOOR_CYCLES; end
        else if (others) mPhase = M_SELECT;
      end
      M_SELECT: begin
        if (mUp && lowUp >= 0) begin mTarget = lowUp; mValid = 1; mPhase = M_ISSUE; end
        else if (highDown >= 0) begin mTarget = highDown; mUp = 0; mValid = 1; mPhase = M_ISSUE; end
        else if (lowUp >= 0) begin mTarget = lowUp; mUp = 1; mValid = 1; mPhase = M_ISSUE; end
        else mPhase = M_IDLE;
      end
      M_ISSUE: begin
        if (target_ready) begin mValid = 0; mPhase = M_MOVING; end
      end
      M_MOVING: begin
        if (arrived) begin mPhase = M_DOOR; mDoor = 1; mDoorLeft = DOOR_CYCLES; end
      end
      M_DOOR: begin
        mDoorLeft--;
        if (mDoorLeft == 0) begin
          mDoor = 0;
          mPhase = anyReq ? M_SELECT : M_IDLE;
        end
      end
      default: mPhase = M_IDLE;
    endcase
    mReq = nextReq;
  endtask

  task automatic checkOutput();
    checkOne("valid", int'(target_valid), int'(mValid));
    checkOne("target", int'(target_floor), mTarget);
    checkOne("pending", int'(pending), int'(modelPend()));
    checkOne("dir_up", int'(dir_up), int'(mUp));
    checkOne("door_open", int'(door_open), int'(mDoor));
  endtask

  // Drive one cycle of inputs, step the model, and compare after the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] hall, input logic cv,
                               input logic [1:0] cf, input logic [1:0] cur,
                               input logic arr, input logic rdy);
    @(negedge clk);
    reset = rst; hall_call = hall; cab_valid = cv; cab_floor = cf;
    cur_floor = cur; arrived = arr; target_ready = rdy;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic waitValid(input logic [1:0] cur);
    int n = 0;
    while (!target_valid && n < 40) begin
      applyStimulus(0, 4'b0000, 0, 2'd0, cur, 0, 0);
      n++;
    end
    checkOne("wait_valid", int'(target_valid), 1);
  endtask

  task automatic waitDoorClosed(input logic [1:0] cur);
    int n = 0;
    while (door_open && n < 40) begin
      applyStimulus(0, 4'b0000, 0, 2'd0, cur, 0, 0);
      n++;
    end
    checkOne("wait_door_closed", int'(door_open), 0);
  endtask

  // Time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    reset = 1; hall_call = '0; cab_valid = 0; cab_floor = '0;
    cur_floor = '0; arrived = 0; target_ready = 0;
    for (int f = 0; f < FLOORS; f++) mReq[f] = 0;

    // Press-to-target latency, handshake hold, 8-cycle dwell, IDLE press at the current floor.
    vecs.push_back(mkVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mkVec(0, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 4'b0010, 1, 0));
    vecs.push_back(mkVec(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 1, 0));
    vecs.push_back(mkVec(0, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 4'b0010, 1, 0));
    vecs.push_back(mkVec(0, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 4'b0010, 1, 0));
    vecs.push_back(mkVec(0, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 4'b0010, 1, 0));
    vecs.push_back(mkVec(0, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 4'b0000, 1, 1));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mkVec(0, 4'b0000, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mkVec(0, 4'b0000, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 1, 0));
    vecs.push_back(mkVec(0, 4'b0100, 0, 0, 2, 0, 0, 0, 1, 4'b0000, 1, 1));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mkVec(0, 4'b0000, 0, 0, 2, 0, 0, 0, 1, 4'b0000, 1, 1));
    vecs.push_back(mkVec(0, 4'b0000, 0, 0, 2, 0, 0, 0, 1, 4'b0000, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].hall, vecs[i].cabV, vecs[i].cabF,
                    vecs[i].cur, vecs[i].arr, vecs[i].rdy);
      checkOne("tbl_valid", int'(target_valid), int'(vecs[i].expValid));
      checkOne("tbl_target", int'(target_floor), int'(vecs[i].expTarget));
      checkOne("tbl_pending", int'(pending), int'(vecs[i].expPend));
      checkOne("tbl_dir_up", int'(dir_up), int'(vecs[i].expDir));
      checkOne("tbl_door", int'(door_open), int'(vecs[i].expDoor));
    end

    // SCAN: from floor 1 going up with floors 0 and 3 pending, go to 3 first, then reverse.
    $display("[TB] scan direction sequence");
    applyStimulus(0, 4'b1001, 0, 0, 1, 0, 0);
    checkOne("scan_pending", int'(pending), 4'b1001);
    waitValid(1);
    checkOne("scan_first_target", int'(target_floor), 3);
    checkOne("scan_first_dir", int'(dir_up), 1);
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 1);
    applyStimulus(0, 4'b0000, 0, 0, 3, 1, 0);
    checkOne("scan_arrive_pending", int'(pending), 4'b0001);
    waitValid(3);
    checkOne("scan_second_target", int'(target_floor), 0);
    checkOne("scan_second_dir", int'(dir_up), 0);
    applyStimulus(0, 4'b0000, 0, 0, 3, 0, 1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 1, 0);
    waitDoorClosed(0);

    // Intermediate stop: heading to 3, a press for 2 is served on the way.
    $display("[TB] intermediate stop sequence");
    applyStimulus(0, 4'b0000, 1, 3, 0, 0, 0);
    waitValid(0);
    checkOne("mid_target", int'(target_floor), 3);
    checkOne("mid_dir", int'(dir_up), 1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);
    applyStimulus(0, 4'b0000, 1, 2, 0, 0, 0);
    checkOne("mid_pending_both", int'(pending), 4'b1100);
    applyStimulus(0, 4'b0000, 0, 0, 2, 1, 0);
    checkOne("mid_pending_cleared", int'(pending), 4'b1000);
    checkOne("mid_door", int'(door_open), 1);
    waitValid(2);
    checkOne("mid_reissue", int'(target_floor), 3);

    // Stalled handshake: target stays put while a nearer request arrives.
    $display("[TB] stalled handshake sequence");
    applyStimulus(0, 4'b0001, 0, 0, 2, 0, 0);
    for (int k = 0; k < 19; k++) begin
      applyStimulus(0, 4'b0000, 0, 0, 2, 0, 0);
      checkOne("stall_valid", int'(target_valid), 1);
      checkOne("stall_target", int'(target_floor), 3);
    end
    checkOne("stall_pending", int'(pending), 4'b1001);
    applyStimulus(0, 4'b0000, 0, 0, 2, 0, 1);
    applyStimulus(1, 4'b0000, 0, 0, 2, 0, 0);

    // Reset while moving with requests outstanding.
    $display("[TB] reset while moving sequence");
    applyStimulus(0, 4'b1010, 0, 0, 0, 0, 0);
    waitValid(0);
    checkOne("rst_target", int'(target_floor), 1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);
    checkOne("rst_pending_before", int'(pending), 4'b1010);
    applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
    checkOne("rst_pending", int'(pending), 0);
    checkOne("rst_valid", int'(target_valid), 0);
    checkOne("rst_door", int'(door_open), 0);
    checkOne("rst_dir", int'(dir_up), 1);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    begin
      logic [1:0] curR = 2'd0;
      for (int n = 0; n < 3000; n++) begin
        logic              rR, cvR, aR, rdR;
        logic [FLOORS-1:0] hR;
        logic [1:0]        cfR;
        rR  = ($urandom_range(0, 299) == 0);
        hR  = ($urandom_range(0, 5) == 0) ? FLOORS'($urandom) : '0;
        cvR = ($urandom_range(0, 5) == 0);
        cfR = 2'($urandom);
        if ($urandom_range(0, 7) == 0) curR = 2'($urandom);
        aR  = ($urandom_range(0, 9) == 0);
        rdR = $urandom_range(0, 1) == 1;
        applyStimulus(rR, hR, cvR, cfR, curR, aR, rdR);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
